// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin shared 8N1 UART transmitter
// One frame per grant: start, 8 data bits LSB first, stop; back-to-back when requests wait.
module uart_tx_sched #(
    parameter int NUM_REQ  = 2,
    parameter int ID_WIDTH = ($clog2(NUM_REQ) > 0) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   pclk,
    input  logic                   rst,
    input  logic                   txclk_en,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ack,
    output logic                   tx,
    output logic                   busy,
    output logic [ID_WIDTH-1:0]    grant_id
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [1:0]          r_state;
    logic                r_tx;
    logic [2:0]          r_last;
    logic [3:0]          r_bit_idx;
    logic [7:0]          r_shreg;
    logic [NUM_REQ-1:0]  r_req_ack;
    logic [ID_WIDTH-1:0] r_grant_id;

    logic [7:0]          w_req_pad;
    logic [63:0]         w_data_pad;
    logic                w_any;
    logic [2:0]          w_win_idx;
    logic [3:0]          w_cand;
    logic                w_take;

    // Widen to the 8-requester maximum so the dynamic selects stay in range.
    assign w_req_pad  = 8'(req_valid);
    assign w_data_pad = 64'(req_data);

    // Search last+1 .. last+NUM_REQ (mod NUM_REQ); the first pending requester wins.
    always_comb begin
        w_any     = 1'b0;
        w_win_idx = '0;
        w_cand    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = {1'b0, r_last} + 4'(k);
            if (w_cand >= 4'(NUM_REQ)) begin
                w_cand = w_cand - 4'(NUM_REQ);
            end
            if (!w_any && w_req_pad[w_cand[2:0]]) begin
                w_any     = 1'b1;
                w_win_idx = w_cand[2:0];
            end
        end
    end

    assign w_take = txclk_en && w_any && ((r_state == ST_IDLE) || (r_state == ST_STOP));

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_tx       <= 1'b1;
            r_last     <= 3'(NUM_REQ - 1);
            r_bit_idx  <= '0;
            r_shreg    <= '0;
            r_req_ack  <= '0;
            r_grant_id <= '0;
        end else begin
            r_req_ack <= '0;
            if (w_take) begin
                r_last     <= w_win_idx;
                r_grant_id <= ID_WIDTH'(w_win_idx);
                r_shreg    <= w_data_pad[{w_win_idx, 3'b000} +: 8];
                r_req_ack  <= NUM_REQ'(1) << w_win_idx;
                r_tx       <= 1'b0;
                r_state    <= ST_START;
            end else if (txclk_en) begin
                case (r_state)
                    ST_IDLE: begin
                        r_tx <= 1'b1;
                    end
                    ST_START: begin
                        r_tx      <= r_shreg[0];
                        r_bit_idx <= 4'd1;
                        r_state   <= ST_DATA;
                    end
                    ST_DATA: begin
                        if (r_bit_idx < 4'd8) begin
                            r_tx      <= r_shreg[r_bit_idx[2:0]];
                            r_bit_idx <= r_bit_idx + 4'd1;
                        end else begin
                            r_tx    <= 1'b1;
                            r_state <= ST_STOP;
                        end
                    end
                    ST_STOP: begin
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_tx    <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign tx       = r_tx;
    assign busy     = (r_state != ST_IDLE);
    assign req_ack  = r_req_ack;
    assign grant_id = r_grant_id;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - scoreboard bench for uart_tx_sched
// Requester queues feed the DUT; a line decoder pops expected (owner, byte) pairs.
module tb_uart_tx_sched;

    localparam int N   = 3;
    localparam int IDW = 2;

    logic           pclk;
    logic           rst;
    logic           txclk_en;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_ack;
    logic           tx;
    logic           busy;
    logic [IDW-1:0] grant_id;

    uart_tx_sched #(.NUM_REQ(N), .ID_WIDTH(IDW)) dut (
        .pclk      (pclk),
        .rst       (rst),
        .txclk_en  (txclk_en),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ack   (req_ack),
        .tx        (tx),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    typedef struct {
        int         id;
        logic [7:0] data;
    } exp_t;

    int         errors = 0;
    int         checks = 0;
    exp_t       exp_q[$];
    int         ack_q[$];
    logic [7:0] rq[N][$];
    logic [7:0] pend[N][$];
    int         m_last = N - 1;

    bit         tie_high = 0;
    int         period = 4;
    int         div_cnt = 0;
    bit         wd_pulse = 0;

    int         mcnt = 0;
    bit         just_stopped = 0;
    int         strobe_n = 0;
    int         start_strobe = 0;
    int         ack_count = 0;
    logic [N-1:0] prev_ack = '0;
    logic       mon_en;
    logic [7:0] rx;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic push_req(input int id, input logic [7:0] d);
        rq[id].push_back(d);
        pend[id].push_back(d);
    endtask

    // Reference order: all bytes pending at once, served round-robin after the last owner.
    task automatic plan();
        bit         more;
        int         c;
        logic [7:0] d;
        more = 1;
        while (more) begin
            more = 0;
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (pend[c].size() > 0) begin
                    d = pend[c].pop_front();
                    exp_q.push_back('{id: c, data: d});
                    ack_q.push_back(c);
                    m_last = c;
                    more   = 1;
                    break;
                end
            end
        end
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(negedge pclk);
            n++;
        end
        chk("drain_in_time", 32'(n < budget), 1);
        @(negedge pclk);
    endtask

    task automatic wait_strobe();
        int n;
        n = 0;
        do begin
            @(posedge pclk);
            n++;
        end while (!txclk_en && n < 2000);
        #1;
    endtask

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    // Strobe generator and requester model; requester drops or re-presents in the ack cycle.
    initial begin
        txclk_en  = 1'b0;
        req_valid = '0;
        req_data  = '0;
        forever begin
            @(negedge pclk);
            if (tie_high) begin
                txclk_en = 1'b1;
            end else if (div_cnt >= period - 1) begin
                div_cnt  = 0;
                txclk_en = 1'b1;
            end else begin
                div_cnt++;
                txclk_en = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (req_ack[i] && rq[i].size() > 0) void'(rq[i].pop_front());
                req_valid[i]       = (rq[i].size() > 0);
                req_data[8*i +: 8] = (rq[i].size() > 0) ? rq[i][0] : 8'h00;
            end
            if (wd_pulse) req_valid[0] = 1'b1;
        end
    end

    // Monitor: ack scoreboard plus a UART line decoder sampled on each strobe.
    initial begin
        exp_t e;
        int   a;
        forever begin
            @(posedge pclk);
            mon_en = txclk_en;
            #1;
            if (rst) begin
                mcnt         = 0;
                just_stopped = 0;
                prev_ack     = '0;
                continue;
            end
            if (req_ack != '0) begin
                ack_count++;
                chk("ack_on_strobe", 32'(mon_en), 1);
                chk("ack_one_cycle", 32'(prev_ack), 0);
                if (ack_q.size() == 0) begin
                    chk("ack_expected", 32'(req_ack), 0);
                end else begin
                    a = ack_q.pop_front();
                    chk("ack_id", 32'(req_ack), 32'(1) << a);
                    chk("ack_grant_id", 32'(grant_id), 32'(a));
                end
            end
            prev_ack = req_ack;
            if (mon_en) begin
                strobe_n++;
                if (mcnt == 0) begin
                    if (just_stopped && exp_q.size() > 0) chk("b2b_start_bit", 32'(tx), 0);
                    just_stopped = 0;
                    if (tx == 1'b0) begin
                        mcnt         = 1;
                        start_strobe = strobe_n;
                        chk("busy_in_frame", 32'(busy), 1);
                    end
                end else if (mcnt <= 8) begin
                    rx[3'(mcnt - 1)] = tx;
                    mcnt++;
                end else begin
                    chk("stop_bit", 32'(tx), 1);
                    chk("frame_len", 32'(strobe_n - start_strobe), 9);
                    chk("busy_at_stop", 32'(busy), 1);
                    if (exp_q.size() == 0) begin
                        chk("frame_expected", 32'(exp_q.size()), 1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("frame_data", 32'(rx), 32'(e.data));
                        chk("frame_grant", 32'(grant_id), 32'(e.id));
                    end
                    mcnt         = 0;
                    just_stopped = 1;
                end
            end
        end
    end

    initial begin
        int cnt[N];
        int sum;
        int n;
        int bc;
        int ack_before;

        rst = 1'b1;
        repeat (3) @(posedge pclk);
        #1;
        chk("reset_tx", 32'(tx), 1);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_ack", 32'(req_ack), 0);
        chk("reset_grant", 32'(grant_id), 0);
        @(negedge pclk);
        rst = 1'b0;

        // Single request at a slow baud
        period = 652;
        @(posedge pclk); #1;
        push_req(0, 8'hA5);
        plan();
        wait_drain(20000);
        chk("single_busy_low", 32'(busy), 0);

        // Simultaneous requests
        period = 5;
        push_req(0, 8'h55);
        push_req(1, 8'h0F);
        plan();
        wait_drain(2000);

        // Fairness: every requester keeps re-presenting
        period = 3;
        for (int i = 0; i < N; i++) begin
            push_req(i, 8'($urandom));
            push_req(i, 8'($urandom));
        end
        plan();
        wait_drain(2000);

        // Randomized batches
        for (int b = 0; b < 10; b++) begin
            period = $urandom_range(1, 6);
            sum = 0;
            for (int i = 0; i < N; i++) begin
                cnt[i] = $urandom_range(0, 2);
                sum += cnt[i];
            end
            if (sum == 0) cnt[$urandom_range(0, N - 1)] = 1;
            for (int i = 0; i < N; i++)
                for (int j = 0; j < cnt[i]; j++) push_req(i, 8'($urandom));
            plan();
            wait_drain(3000);
        end

        // Withdrawn request between strobes
        period = 8;
        ack_before = ack_count;
        wait_strobe();
        wd_pulse = 1'b1;
        repeat (2) @(posedge pclk);
        #1;
        wd_pulse = 1'b0;
        for (int s = 0; s < 3; s++) begin
            wait_strobe();
            chk("withdrawn_tx_idle", 32'(tx), 1);
        end
        chk("withdrawn_no_ack", 32'(ack_count), 32'(ack_before));
        chk("withdrawn_not_busy", 32'(busy), 0);

        // Reset during data bit 4
        period = 4;
        push_req(1, 8'hC3);
        plan();
        n = 0;
        while (mcnt != 6 && n < 500) begin
            @(negedge pclk);
            n++;
        end
        chk("reset_reach_bit4", 32'(n < 500), 1);
        rst = 1'b1;
        #1;
        chk("midreset_tx", 32'(tx), 1);
        chk("midreset_busy", 32'(busy), 0);
        exp_q.delete();
        ack_q.delete();
        m_last = N - 1;
        repeat (3) @(negedge pclk);
        rst = 1'b0;
        for (int i = 0; i < N; i++) push_req(i, 8'($urandom));
        plan();
        wait_drain(2000);

        // Strobe tied high: one bit per cycle
        tie_high = 1'b1;
        @(posedge pclk); #1;
        push_req(2, 8'($urandom));
        plan();
        n = 0;
        while (!busy && n < 20) begin
            @(posedge pclk); #1;
            n++;
        end
        bc = 0;
        while (busy && bc < 30) begin
            bc++;
            @(posedge pclk); #1;
        end
        chk("tie_high_frame_cycles", 32'(bc), 10);
        wait_drain(200);
        push_req(0, 8'($urandom));
        push_req(1, 8'($urandom));
        push_req(2, 8'($urandom));
        plan();
        wait_drain(200);
        tie_high = 1'b0;

        chk("exp_q_empty", 32'(exp_q.size()), 0);
        chk("ack_q_empty", 32'(ack_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

- Shares one 8N1 UART transmit line among `NUM_REQ` byte sources using round-robin arbitration.
- Serialises each granted byte, one bit per `txclk_en` strobe from the baud rate generator.
- Sits between the on-chip message producers and the board TX pin.
- Provides back-to-back frames with no idle gap when requests are pending.

## Interface

Parameters:
- `NUM_REQ`, default 2. Number of requesters; legal range 1..8.
- `ID_WIDTH`, default `($clog2(NUM_REQ) > 0) ? $clog2(NUM_REQ) : 1`. Width of `grant_id`.

Ports:
- `pclk` input 1. Single system clock; all logic on its rising edge.
- `rst` input 1. Asynchronous, active-high reset.
- `txclk_en` input 1. One-cycle bit-rate strobe from the baud generator; period is one bit time.
- `req_valid` input `NUM_REQ`. Bit i high means requester i has a byte pending.
- `req_data` input `8*NUM_REQ`. Byte for requester i is in bits [8i+7:8i].
- `req_ack` output `NUM_REQ`. One-cycle pulse on bit i when requester i's byte is accepted.
- `tx` output 1. Serial line; idle high, LSB first.
- `busy` output 1. High while a frame is on the line.
- `grant_id` output `ID_WIDTH`. Index of the requester owning the current or last frame.

## Operation

- States are IDLE, START, DATA and STOP. All state, `tx` and `bit_idx` updates occur only on cycles with `txclk_en`=1; `req_ack` is the only exception.
- **Arbitration:**
  - A 3-bit pointer `last` (reset `NUM_REQ-1`) sets priority.
  - Search order is `last+1`, `last+2`, …, `last+NUM_REQ`, each mod `NUM_REQ`. The first i with `req_valid[i]`=1 wins.
  - On a win: `last<=i`, `grant_id<=i`, `shreg<=req_data[8i+:8]`, `req_ack[i]<=1` for exactly one cycle.
- **IDLE**
  - Holds `tx`=1 and `busy`=0.
  - On `txclk_en` with any `req_valid`: arbitrate, `tx<=0` (start bit), go to START.
- **START**
  - On `txclk_en`: `tx<=shreg[0]`, `bit_idx<=1`, go to DATA.
- **DATA**
  - On `txclk_en` with `bit_idx`<8: `tx<=shreg[bit_idx]`, `bit_idx<=bit_idx+1`.
  - On `txclk_en` with `bit_idx`==8: `tx<=1` (stop bit), go to STOP.
- **STOP**
  - On `txclk_en` with any `req_valid`: arbitrate, `tx<=0`, go to START. This gives a back-to-back frame with exactly one stop bit.
  - On `txclk_en` with no request: go to IDLE (`tx` stays 1).
- `busy` is 1 in START, DATA and STOP.
- Requester contract:
  - Hold `req_valid` and data stable until `req_ack`.
  - Deassert `req_valid` in the cycle `req_ack` is seen, or re-present the next byte.
  - Dropping `req_valid` before acceptance is legal; that requester is then skipped.
- `bit_idx` is 4 bits and never exceeds 8.
- `shreg` is fixed once latched. Later changes on `req_data` do not affect the frame in flight.

## Timing

- Reset values:
  - `tx`=1, `busy`=0, `req_ack`=0, `grant_id`=0.
  - State IDLE, `last`=`NUM_REQ-1`, `bit_idx`=0.
- Reset takes effect immediately and asynchronously, including mid-frame. `tx` returns high without completing the frame, and the aborted byte is not retransmitted.
- Acceptance latency:
  - `req_ack` is registered.
  - It is high the cycle after the `txclk_en` edge that samples the request.
  - `tx`, `busy` and `grant_id` change on that same edge.
- Frame length:
  - A frame lasts exactly 10 `txclk_en` periods: 1 start, 8 data, 1 stop.
  - With continuous requests, frame n+1's start bit begins exactly 10 strobes after frame n's start bit.
- Request arrival:
  - A request arriving while `txclk_en`=0 in IDLE waits for the next strobe; worst case is one bit time.
  - Requests arriving mid-frame are considered only at the STOP-state strobe.
- `txclk_en` held high continuously is legal: one bit per `pclk` cycle, frame = 10 cycles.

## Test plan

- **Single request:** `NUM_REQ`=2, `txclk_en` every 652 cycles, `req_valid`=01, data 0xA5.
  - `req_ack`=01 for one cycle.
  - `tx` sequence 0,1,0,1,0,0,1,0,1,1, each bit 652 cycles.
  - `busy` low after the stop bit.
- **Simultaneous requests:** `req_valid`=11, data0=0x55, data1=0x0F, first requester drops `valid` on ack.
  - Frame 0x55 (`grant_id`=0), then 0x0F (`grant_id`=1) back-to-back.
  - Exactly 10 strobes between start bits; no idle bit.
- **Fairness:** `NUM_REQ`=3, all `req_valid` held high with re-presented bytes.
  - Grants follow 0,1,2,0,1,2.
  - Each `req_ack` pulse is one cycle.
- **Reset mid-frame:** assert `rst` during data bit 4.
  - `tx`=1 and `busy`=0 in the same cycle.
  - After release, a new request is accepted with a full frame starting with grant 0.
- **Withdrawn request:** `req_valid[0]` pulsed high between strobes and dropped before the next strobe.
  - No ack, `tx` stays 1.
  - With `txclk_en` tied high, a request yields a 10-cycle frame.
